// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, BTB entry layout and counter helper.
// Fields are sized for the widest BTB configuration (tag up to 32 bits, counter up to 4 bits).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W_MAX  = 4;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    logic  valid;
    word_t tag;
    word_t target;
    cnt_t  cnt;
  } btb_entry_t;

  // Saturating up/down step bounded by 0 and cnt_max.
  function automatic cnt_t sat_step(input cnt_t cnt, input logic up, input cnt_t cnt_max);
    cnt_t res;
    if (up) begin
      if (cnt == cnt_max) res = cnt;
      else                res = cnt + 4'd1;
    end else begin
      if (cnt == 4'd0)    res = cnt;
      else                res = cnt - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_return_stack.sv
// Circular return-address stack; the oldest entry is overwritten on overflow.
// Present only when BRANCH_PREDICTOR_RAS_EN is defined.
`ifdef BRANCH_PREDICTOR_RAS_EN
module return_stack
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push_i,
  input  logic  pop_i,
  input  word_t push_data_i,
  output word_t top_o,
  output logic  empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  word_t            stack_q [DEPTH];
  word_t            stack_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr_s;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop_s;

  assign top_ptr_s = ptr_q - PTR_W'(1);
  assign top_o     = stack_q[top_ptr_s];
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i && !empty_o;

  // Next-state: push and pop together rewrite the top in place.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push_i && do_pop_s) begin
      stack_d[top_ptr_s] = push_data_i;
    end else if (push_i) begin
      stack_d[ptr_q] = push_data_i;
      ptr_d          = ptr_q + PTR_W'(1);
      count_d        = (count_q == CNT_FULL) ? count_q : count_q + (PTR_W+1)'(1);
    end else if (do_pop_s) begin
      ptr_d   = top_ptr_s;
      count_d = count_q - (PTR_W+1)'(1);
    end else begin
      stack_d = stack_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 32'h0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters; zero-latency lookup, update at retire.
// Define BRANCH_PREDICTOR_RAS_EN to add a return-address stack that overrides the BTB on JR $31.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  input  logic        ret_hint,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        call_valid,
  input  logic [31:0] call_ret_addr,
  output logic        mispredict
);

  localparam int   IDX_W      = $clog2(ENTRIES);
  localparam cnt_t CNT_MAX    = cnt_t'((1 << CNT_W) - 1);
  localparam cnt_t CNT_WEAK_T = cnt_t'(1 << (CNT_W - 1));
  localparam cnt_t CNT_RST    = cnt_t'((1 << (CNT_W - 1)) - 1);

  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];
  logic [IDX_W-1:0] lk_idx_s, up_idx_s;
  word_t            lk_tag_s, up_tag_s;
  btb_entry_t       lk_ent_s, up_ent_s;
  logic             btb_taken_s, ras_pop_s;
  word_t            ras_top_s, seq_pc_s;

  assign lk_idx_s    = lookup_pc[IDX_W+1:2];
  assign lk_tag_s    = lookup_pc >> (IDX_W + 2);
  assign up_idx_s    = upd_pc[IDX_W+1:2];
  assign up_tag_s    = upd_pc >> (IDX_W + 2);
  assign lk_ent_s    = btb_q[lk_idx_s];
  assign up_ent_s    = btb_q[up_idx_s];
  assign btb_taken_s = lk_ent_s.valid && (lk_ent_s.tag == lk_tag_s) && lk_ent_s.cnt[CNT_W-1];
  assign seq_pc_s    = lookup_pc + 32'(WORD_BYTES);

`ifdef BRANCH_PREDICTOR_RAS_EN
  logic ras_empty_s;

  assign ras_pop_s = ret_hint && !ras_empty_s;

  return_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .CLK        (CLK),
    .nRST       (nRST),
    .push_i     (call_valid),
    .pop_i      (ras_pop_s),
    .push_data_i(call_ret_addr),
    .top_o      (ras_top_s),
    .empty_o    (ras_empty_s)
  );
`else
  logic unused_ras_s;

  assign unused_ras_s = ^{ret_hint, call_valid, call_ret_addr};
  assign ras_pop_s    = 1'b0;
  assign ras_top_s    = 32'h0;
`endif

  // Prediction: a live return address beats the BTB.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = seq_pc_s;
    if (ras_pop_s) begin
      pred_taken  = 1'b1;
      pred_target = ras_top_s;
    end else if (btb_taken_s) begin
      pred_taken  = 1'b1;
      pred_target = lk_ent_s.target;
    end else begin
      pred_taken  = 1'b0;
      pred_target = seq_pc_s;
    end
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  // Training: hits step the counter, taken misses replace the slot outright.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid) begin
      if (up_ent_s.valid && (up_ent_s.tag == up_tag_s)) begin
        btb_d[up_idx_s].cnt = sat_step(up_ent_s.cnt, upd_taken, CNT_MAX);
        if (upd_taken) btb_d[up_idx_s].target = upd_target;
        else           btb_d[up_idx_s].target = up_ent_s.target;
      end else if (upd_taken) begin
        btb_d[up_idx_s] = '{valid: 1'b1, tag: up_tag_s, target: upd_target, cnt: CNT_WEAK_T};
      end else begin
        btb_d[up_idx_s] = up_ent_s;
      end
    end else begin
      btb_d = btb_q;
    end
  end

  // BTB storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: 32'h0, target: 32'h0, cnt: CNT_RST};
      end
    end else begin
      btb_q <= btb_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=2, RAS_DEPTH=4).
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        ret_hint;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken, upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        call_valid;
  logic [31:0] call_ret_addr;
  logic        mispredict;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(16), .CNT_W(2), .RAS_DEPTH(4)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .lookup_pc      (lookup_pc),
    .ret_hint       (ret_hint),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .call_valid     (call_valid),
    .call_ret_addr  (call_ret_addr),
    .mispredict     (mispredict)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
    lookup_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    chk({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge CLK);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_target      = tgt;
    upd_taken       = tk;
    upd_pred_taken  = tk;
    upd_pred_target = tgt;
    @(posedge CLK);
    #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; lookup_pc = 32'h0; ret_hint = 1'b0; upd_valid = 1'b0;
    upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
    upd_pred_target = 32'h0; call_valid = 1'b0; call_ret_addr = 32'h0;

    // Outputs while held in reset; mispredict stays combinational.
    #2;
    look("rst_hold", 32'h40, 1'b0, 32'h44);
    upd_valid = 1'b1; upd_taken = 1'b1; upd_pred_taken = 1'b0; upd_pc = 32'h40; upd_target = 32'h100;
    #1;
    chk("rst_mispredict", {31'd0, mispredict}, 32'd1);
    @(posedge CLK); #1;
    upd_valid = 1'b0;
    look("rst_no_update", 32'h40, 1'b0, 32'h44);
    @(negedge CLK); nRST = 1'b1;

    look("after_rst", 32'h40, 1'b0, 32'h44);
    look("after_rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocate weakly taken, then train down.
    do_upd(32'h40, 32'h100, 1'b1);
    look("alloc", 32'h40, 1'b1, 32'h100);
    do_upd(32'h40, 32'h100, 1'b0);
    look("nt1", 32'h40, 1'b0, 32'h44);
    do_upd(32'h40, 32'h100, 1'b0);
    look("nt2", 32'h40, 1'b0, 32'h44);

    // Counter 0 -> saturate at 3 -> one not-taken leaves 2.
    for (int i = 0; i < 4; i++) do_upd(32'h40, 32'h100, 1'b1);
    look("sat_hi", 32'h40, 1'b1, 32'h100);
    do_upd(32'h40, 32'h100, 1'b0);
    look("sat_hi_nt", 32'h40, 1'b1, 32'h100);

    // 2 -> 0 with an extra not-taken, then one taken leaves 1 (not taken).
    for (int i = 0; i < 3; i++) do_upd(32'h40, 32'h100, 1'b0);
    do_upd(32'h40, 32'h100, 1'b1);
    look("sat_lo", 32'h40, 1'b0, 32'h44);
    do_upd(32'h40, 32'h180, 1'b1);
    look("retarget", 32'h40, 1'b1, 32'h180);

    // Same index, different tag replaces the entry.
    do_upd(32'h80, 32'h300, 1'b1);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 32'h300);

    // Not-taken miss allocates nothing.
    do_upd(32'h44, 32'h500, 1'b0);
    look("nt_miss", 32'h44, 1'b0, 32'h48);

    // Same-cycle lookup and update: lookup sees old contents until the edge.
    @(negedge CLK);
    upd_valid = 1'b1; upd_pc = 32'h48; upd_target = 32'h400; upd_taken = 1'b1;
    look("same_cycle_pre", 32'h48, 1'b0, 32'h4C);
    @(posedge CLK); #1;
    upd_valid = 1'b0;
    look("same_cycle_post", 32'h48, 1'b1, 32'h400);

    // Mispredict combinations, all resolved before the next edge.
    @(negedge CLK);
    upd_pc = 32'h3C0; upd_valid = 1'b1;
    upd_taken = 1'b1; upd_pred_taken = 1'b1; upd_target = 32'h200; upd_pred_target = 32'h204;
    #1; chk("mp_target", {31'd0, mispredict}, 32'd1);
    upd_pred_target = 32'h200;
    #1; chk("mp_match", {31'd0, mispredict}, 32'd0);
    upd_taken = 1'b0; upd_pred_taken = 1'b0; upd_pred_target = 32'h204;
    #1; chk("mp_nt_tgt", {31'd0, mispredict}, 32'd0);
    upd_pred_taken = 1'b1;
    #1; chk("mp_dir", {31'd0, mispredict}, 32'd1);
    upd_valid = 1'b0;
    #0.5; chk("mp_idle", {31'd0, mispredict}, 32'd0);

`ifdef BRANCH_PREDICTOR_RAS_EN
    // Five calls into a 4-deep stack, then five returns.
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK); call_valid = 1'b1; call_ret_addr = 32'(i * 16);
    end
    @(negedge CLK); call_valid = 1'b0;
    lookup_pc = 32'h80; ret_hint = 1'b1;
    #1; chk("ras_pop1", pred_target, 32'h50);
    chk("ras_pop1_taken", {31'd0, pred_taken}, 32'd1);
    @(negedge CLK); #1; chk("ras_pop2", pred_target, 32'h40);
    @(negedge CLK); #1; chk("ras_pop3", pred_target, 32'h30);
    @(negedge CLK); #1; chk("ras_pop4", pred_target, 32'h20);
    @(negedge CLK); #1; chk("ras_empty_btb", pred_target, 32'h300);
    lookup_pc = 32'h500;
    #1; chk("ras_empty_seq", pred_target, 32'h504);
    chk("ras_empty_seq_taken", {31'd0, pred_taken}, 32'd0);
    @(negedge CLK); ret_hint = 1'b0;
`else
    // Return-stack inputs have no effect.
    @(negedge CLK); call_valid = 1'b1; call_ret_addr = 32'h10;
    @(negedge CLK); call_valid = 1'b0; ret_hint = 1'b1;
    look("noras_miss", 32'h500, 1'b0, 32'h504);
    look("noras_hit", 32'h80, 1'b1, 32'h300);
    @(negedge CLK); ret_hint = 1'b0;
`endif

    // Asynchronous reset mid-cycle wipes all history immediately.
    @(posedge CLK); #2;
    nRST = 1'b0;
    look("mid_rst", 32'h80, 1'b0, 32'h84);
    @(negedge CLK); nRST = 1'b1;
    look("mid_rst_rel", 32'h48, 1'b0, 32'h4C);
    do_upd(32'h80, 32'h600, 1'b1);
    look("realloc", 32'h80, 1'b1, 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
